// File: rtl/bf16_drain_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf16_drain_sched_pkg
// Brief    : Shared widths, exponent bias and FSM encoding for the drain block
// Revision : 1.0
// ============================================================================
package bf16_drain_sched_pkg;

    localparam int ACC_W      = 18;
    localparam int BF16_W     = 16;
    localparam int EXP_OFFSET = 109;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_conv = 2'd1;
    localparam logic [1:0] c_st_send = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bf16_drain_sched_norm.sv
`default_nettype none
// ============================================================================
// Module   : bf16_drain_sched_norm
// Brief    : Combinational int18 -> bf16 normalizer (truncating mantissa)
// Revision : 1.0
// ============================================================================
module bf16_drain_sched_norm
    import bf16_drain_sched_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    output logic [BF16_W-1:0] bf16
);

    logic [ACC_W-1:0] w_mag;
    logic [4:0]       w_pos;
    logic [4:0]       w_shift;
    logic [7:0]       w_exp;
    logic [6:0]       w_mant;

    always_comb begin
        // Full 18-bit unsigned magnitude so -2^17 still normalizes correctly
        w_mag = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;
        w_pos = 5'd0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_mag[i]) begin
                w_pos = 5'(i);
            end
        end
        w_shift = 5'(ACC_W - 1) - w_pos;
        w_exp   = 8'(w_pos) + 8'(EXP_OFFSET);
        w_mant  = 7'((w_mag << w_shift) >> (ACC_W - 8));
        bf16    = (w_mag == '0) ? '0 : {acc[ACC_W-1], w_exp, w_mant};
    end

endmodule
`default_nettype wire

// File: rtl/bf16_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : bf16_drain_sched
// Brief    : Captures a frame of int18 lanes and drains it as bf16 beats
// Revision : 1.0
// ============================================================================
module bf16_drain_sched
    import bf16_drain_sched_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    localparam int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [NUM_LANES*ACC_W-1:0] load_data,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BF16_W-1:0]          out_data,
    output logic [IDX_W-1:0]           out_lane,
    output logic                       out_last,
    output logic                       busy,
    output logic [15:0]                frames_done
);

    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_LANES - 1);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ACC_W-1:0]  r_lanes [NUM_LANES];
    logic              r_out_valid;
    logic [BF16_W-1:0] r_out_data;
    logic [IDX_W-1:0]  r_out_lane;
    logic              r_out_last;
    logic [15:0]       r_frames_done;

    logic              w_accept;
    logic [IDX_W-1:0]  w_next_idx;
    logic [ACC_W-1:0]  w_conv_in;
    logic [BF16_W-1:0] w_conv_out;

    assign w_accept = load_valid && (r_state == c_st_idle);

    // The converter looks one lane ahead while in SEND so a beat is ready every cycle
    always_comb begin
        w_next_idx = (r_state == c_st_send) ? (r_idx + c_idx_one) : r_idx;
        w_conv_in  = r_lanes[w_next_idx];
    end

    bf16_drain_sched_norm u_norm (
        .acc  (w_conv_in),
        .bf16 (w_conv_out)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_lanes[k] <= load_data[k*ACC_W +: ACC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_idx         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_lane    <= '0;
            r_out_last    <= 1'b0;
            r_frames_done <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (load_valid) begin
                        r_idx   <= '0;
                        r_state <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    if (abort) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else begin
                        r_out_data  <= w_conv_out;
                        r_out_lane  <= w_next_idx;
                        r_out_last  <= (w_next_idx == c_idx_last);
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_send;
                    end
                end
                c_st_send: begin
                    // Abort wins over a coincident handshake; the frame is not counted
                    if (abort) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (r_idx == c_idx_last) begin
                            r_state       <= c_st_idle;
                            r_out_valid   <= 1'b0;
                            r_out_last    <= 1'b0;
                            r_frames_done <= r_frames_done + 16'd1;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_out_data <= w_conv_out;
                            r_out_lane <= w_next_idx;
                            r_out_last <= (w_next_idx == c_idx_last);
                        end
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready  = (r_state == c_st_idle);
    assign busy        = (r_state != c_st_idle);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_lane    = r_out_lane;
    assign out_last    = r_out_last;
    assign frames_done = r_frames_done;

endmodule
`default_nettype wire

// File: tb/tb_bf16_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf16_drain_sched
// Brief    : Directed self-checking bench for bf16_drain_sched (NUM_LANES=4)
// Revision : 1.0
// ============================================================================
module tb_bf16_drain_sched;

    localparam int NUM_LANES = 4;
    localparam int IDX_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    load_valid;
    logic                    load_ready;
    logic [NUM_LANES*18-1:0] load_data;
    logic                    abort;
    logic                    out_valid;
    logic                    out_ready;
    logic [15:0]             out_data;
    logic [IDX_W-1:0]        out_lane;
    logic                    out_last;
    logic                    busy;
    logic [15:0]             frames_done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_frames;

    // lanes {0, 1, -1, 2} and {3, -4, 131071, -131072}, lane 0 in the LSBs
    logic [71:0] frame_a;
    logic [71:0] frame_b;
    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];

    always #5 clk = ~clk;

    bf16_drain_sched #(.NUM_LANES(NUM_LANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_lane    (out_lane),
        .out_last    (out_last),
        .busy        (busy),
        .frames_done (frames_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_frames = 16'd0;
    endtask

    // Accept a frame from IDLE and check the two-cycle latency to the first beat
    task automatic send_frame(input logic [71:0] d, input logic with_abort);
        load_valid = 1'b1;
        load_data  = d;
        abort      = with_abort;
        tick();
        load_valid = 1'b0;
        abort      = 1'b0;
        load_data  = '1;
        checks++;
        if (busy !== 1'b1 || load_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept: busy=%b load_ready=%b out_valid=%b, required 1 0 0",
                     busy, load_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%b two cycles after accept, required 1", out_valid);
        end
    endtask

    task automatic collect(input logic [15:0] e [4], input int stall_lane, input int stall_n,
                           input int abort_lane);
        int waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: out_valid=%b after %0d cycles, required 1", out_valid, waited);
            return;
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[b] || out_lane !== IDX_W'(b) ||
                out_last !== (b == 3)) begin
                errors++;
                $display("FAIL beat%0d: valid=%b data=%h lane=%0d last=%b, required 1 %h %0d %b",
                         b, out_valid, out_data, out_lane, out_last, e[b], b, (b == 3));
            end
            if (b == abort_lane) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 ||
                    frames_done !== exp_frames) begin
                    errors++;
                    $display("FAIL abort: valid=%b busy=%b ready=%b frames=%h, required 0 0 1 %h",
                             out_valid, busy, load_ready, frames_done, exp_frames);
                end
                return;
            end
            if (b == stall_lane) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== e[b] || out_lane !== IDX_W'(b) ||
                        out_last !== (b == 3)) begin
                        errors++;
                        $display("FAIL stall%0d: valid=%b data=%h lane=%0d last=%b, required 1 %h %0d %b",
                                 s, out_valid, out_data, out_lane, out_last, e[b], b, (b == 3));
                    end
                end
                out_ready = 1'b1;
            end
            tick();
        end
        exp_frames = exp_frames + 16'd1;
        checks++;
        if (out_valid !== 1'b0 || frames_done !== exp_frames || busy !== 1'b0 ||
            load_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_end: valid=%b frames=%h busy=%b ready=%b, required 0 %h 0 1",
                     out_valid, frames_done, busy, load_ready, exp_frames);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0 || frames_done !== 16'd0 || busy !== 1'b0 ||
            out_data !== 16'h0000 || out_lane !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b frames=%h busy=%b data=%h lane=%0d last=%b",
                     load_ready, out_valid, frames_done, busy, out_data, out_lane, out_last);
        end
    endtask

    task automatic test_basic();
        send_frame(frame_a, 1'b0);
        collect(exp_a, -1, 0, -1);
        send_frame(frame_b, 1'b0);
        collect(exp_b, -1, 0, -1);
    endtask

    task automatic test_backpressure();
        send_frame(frame_a, 1'b0);
        collect(exp_a, 1, 3, -1);
    endtask

    task automatic test_abort();
        send_frame(frame_b, 1'b0);
        collect(exp_b, -1, 0, 2);
        // abort coinciding with load in IDLE must not block the accept
        send_frame(frame_b, 1'b1);
        collect(exp_b, -1, 0, -1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_valid = 1'b1;
        load_data  = frame_a;
        tick();
        load_data = frame_b;
        tick();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a[b] || out_lane !== IDX_W'(b)) begin
                errors++;
                $display("FAIL b2b_beat%0d: valid=%b data=%h lane=%0d, required 1 %h %0d",
                         b, out_valid, out_data, out_lane, exp_a[b], b);
            end
            tick();
        end
        exp_frames = exp_frames + 16'd1;
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || frames_done !== exp_frames) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b busy=%b frames=%h, required 1 0 %h",
                     load_ready, busy, frames_done, exp_frames);
        end
        tick();
        load_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b ready=%b, required 1 0", busy, load_ready);
        end
        collect(exp_b, -1, 0, -1);
        checks++;
        if (frames_done !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count: frames=%h, required 0002", frames_done);
        end
    endtask

    task automatic test_reset_in_send();
        send_frame(frame_a, 1'b0);
        tick();
        checks++;
        if (out_lane !== IDX_W'(1) || out_data !== 16'h3680) begin
            errors++;
            $display("FAIL pre_rst: lane=%0d data=%h, required 1 3680", out_lane, out_data);
        end
        rst   = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        abort = 1'b0;
        exp_frames = 16'd0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b0 || frames_done !== 16'd0 || busy !== 1'b0 ||
                load_ready !== 1'b1 || out_data !== 16'h0000 || out_lane !== '0) begin
                errors++;
                $display("FAIL rst_send%0d: valid=%b frames=%h busy=%b ready=%b data=%h lane=%0d",
                         c, out_valid, frames_done, busy, load_ready, out_data, out_lane);
            end
            tick();
        end
        send_frame(frame_b, 1'b0);
        collect(exp_b, -1, 0, -1);
    endtask

    task automatic test_wrap();
        force dut.r_frames_done = 16'hFFFF;
        tick();
        release dut.r_frames_done;
        exp_frames = 16'hFFFF;
        checks++;
        if (frames_done !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset: frames=%h, required ffff", frames_done);
        end
        send_frame(frame_a, 1'b0);
        collect(exp_a, -1, 0, -1);
        checks++;
        if (frames_done !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: frames=%h, required 0000", frames_done);
        end
    endtask

    initial begin
        frame_a    = {18'd2, 18'h3FFFF, 18'd1, 18'd0};
        frame_b    = {18'h20000, 18'h1FFFF, 18'h3FFFC, 18'd3};
        exp_a      = '{16'h0000, 16'h3680, 16'hB680, 16'h3700};
        exp_b      = '{16'h3740, 16'hB780, 16'h3EFF, 16'hBF00};
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        exp_frames = 16'd0;

        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_in_send();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
